fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types: datapath widths, reset/NOP constants,
// fetch FSM state encoding and the {pc, instruction} payload record.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
//   master (fetch side): drives imem_req_valid/imem_req_addr,
//                        receives imem_req_ready/imem_rsp_valid/imem_rsp_data.
//   slave  (memory side): the mirror image.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instruction} holding buffer for a response that arrives
// while the decode slot is stalled.
//   clk, rst_n : clock, synchronous active-low reset
//   push/pop   : load din / release the entry
//   flush      : discard the entry (wins over push and pop)
//   full, dout : occupancy and held entry
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output fetch_entry_t dout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem request at a time, tracks it
// through REQ/WAIT/DROP, and presents fetched words to decode through a
// registered if_id slot backed by a one-entry skid buffer.
//   clk, rst_n        : clock, synchronous active-low reset
//   imem              : memory request/response channel (master side)
//   redirect_valid/pc : branch/jump/flush target from a later stage
//   stall             : decode cannot consume this cycle
//   if_id_*           : instruction slot handed to decode
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [ILEN-1:0] if_id_instruction
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic            req_valid_c;
    logic            handshake_c;
    logic            deliver_c;
    logic            slot_free_c;
    logic            skid_full;
    fetch_entry_t    skid_entry;
    fetch_entry_t    rsp_entry_c;

    // Request is gated by reset so nothing leaks out before the first edge.
    assign req_valid_c         = rst_n && (state_q == FETCH_REQ) && !skid_full;
    assign imem.imem_req_valid = req_valid_c;
    assign imem.imem_req_addr  = pc_q;

    assign handshake_c = req_valid_c && imem.imem_req_ready;
    assign slot_free_c = !if_id_valid || !stall;
    assign rsp_entry_c = '{pc: inflight_pc_q, instr: imem.imem_rsp_data};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH_REQ;
        else        state_q <= state_d;
    end

    // Next state; a redirect turns any live or just-issued request stale.
    always_comb begin
        state_d   = state_q;
        deliver_c = 1'b0;
        case (state_q)
            FETCH_REQ: begin
                if (handshake_c) state_d = redirect_valid ? FETCH_DROP : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d   = FETCH_REQ;
                    deliver_c = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem.imem_rsp_valid) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    // Fetch PC and the address of the request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            if (handshake_c) inflight_pc_q <= pc_q;
            if (redirect_valid)  pc_q <= align_word(redirect_pc);
            else if (deliver_c)  pc_q <= inflight_pc_q + XLEN'(4);
        end
    end

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (deliver_c && !slot_free_c),
        .pop   (slot_free_c && skid_full),
        .flush (redirect_valid),
        .din   (rsp_entry_c),
        .full  (skid_full),
        .dout  (skid_entry)
    );

    // Decode slot: skid entry drains first; a response can only arrive
    // while the skid is empty because requests stop once it fills.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_valid       <= 1'b0;
            if_id_pc          <= RESET_PC;
            if_id_pc_plus4    <= RESET_PC + XLEN'(4);
            if_id_instruction <= NOP_INSTR;
        end else if (redirect_valid) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
        end else if (slot_free_c) begin
            if (skid_full) begin
                if_id_valid       <= 1'b1;
                if_id_pc          <= skid_entry.pc;
                if_id_pc_plus4    <= skid_entry.pc + XLEN'(4);
                if_id_instruction <= skid_entry.instr;
            end else if (deliver_c) begin
                if_id_valid       <= 1'b1;
                if_id_pc          <= rsp_entry_c.pc;
                if_id_pc_plus4    <= rsp_entry_c.pc + XLEN'(4);
                if_id_instruction <= rsp_entry_c.instr;
            end else begin
                if_id_valid       <= 1'b0;
                if_id_instruction <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the main instance plus a
// hand-written sequence on a second instance with RESET_PC at the top of memory.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instruction;
    fetch_unit_if mem_a ();

    fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem              (mem_a),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall             (stall),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction)
    );

    // wrap-around instance
    logic        rst_b = 1'b0;
    logic        redirect_valid_b = 1'b0;
    logic [31:0] redirect_pc_b = '0;
    logic        stall_b = 1'b0;
    logic        v_b;
    logic [31:0] pc_b, pc4_b, instr_b;
    fetch_unit_if mem_b ();

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk               (clk),
        .rst_n             (rst_b),
        .imem              (mem_b),
        .redirect_valid    (redirect_valid_b),
        .redirect_pc       (redirect_pc_b),
        .stall             (stall_b),
        .if_id_valid       (v_b),
        .if_id_pc          (pc_b),
        .if_id_pc_plus4    (pc4_b),
        .if_id_instruction (instr_b)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        redir;
        logic [31:0] rpc;
        logic        stl;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rsp_v,
                                input logic [31:0] rsp_d, input logic redir,
                                input logic [31:0] rpc, input logic stl,
                                input logic e_rv, input logic [31:0] e_addr,
                                input logic e_v, input logic [31:0] e_pc,
                                input logic [31:0] e_pc4, input logic [31:0] e_instr);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rsp_v = rsp_v; r.rsp_d = rsp_d;
        r.redir = redir; r.rpc = rpc; r.stl = stl;
        r.e_rv = e_rv; r.e_addr = e_addr; r.e_v = e_v;
        r.e_pc = e_pc; r.e_pc4 = e_pc4; r.e_instr = e_instr;
        return r;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    initial begin
        mem_a.imem_req_ready = 1'b0;
        mem_a.imem_rsp_valid = 1'b0;
        mem_a.imem_rsp_data  = '0;
        mem_b.imem_req_ready = 1'b0;
        mem_b.imem_rsp_valid = 1'b0;
        mem_b.imem_rsp_data  = '0;

        //   rst rdy rsp data          rd  rpc    stl  rv addr      v  pc      pc4     instr
        // 3 cycles not ready, accepted on the 4th, first fetch delivered
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'h00500093, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h4,   1, 32'h0,   32'h4,  32'h00500093));
        tbl.push_back(mk(1, 0, 1, 32'h00400113, 0, 32'h0,   0,  0, 32'h4,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h8,   1, 32'h4,   32'h8,  32'h00400113));
        // redirect while waiting on addr 8: that response is dropped
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h100, 0,  0, 32'h8,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 0, 32'h0,   0,  0, 32'h100, 0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h100, 0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'h00700193, 0, 32'h0,   0,  0, 32'h100, 0, 32'h0,   32'h0,  NOP));
        // misaligned redirect under stall kills a valid output
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h202, 1,  1, 32'h104, 1, 32'h100, 32'h104, 32'h00700193));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   1,  1, 32'h200, 0, 32'h0,   32'h0,  NOP));
        // reset mid-WAIT, late response ignored
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h200, 0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,   0,  0, 32'h200, 0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'hBADBAD00, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        // two responses under stall: output holds addr 0, skid holds addr 4
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'h11111093, 0, 32'h0,   1,  0, 32'h0,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  1, 32'h4,   1, 32'h0,   32'h4,  32'h11111093));
        tbl.push_back(mk(1, 0, 1, 32'h22222113, 0, 32'h0,   1,  0, 32'h4,   1, 32'h0,   32'h4,  32'h11111093));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   1,  0, 32'h8,   1, 32'h0,   32'h4,  32'h11111093));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  0, 32'h8,   1, 32'h0,   32'h4,  32'h11111093));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h8,   1, 32'h4,   32'h8,  32'h22222113));
        tbl.push_back(mk(1, 0, 1, 32'h33333193, 0, 32'h0,   0,  0, 32'h8,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'hC,   1, 32'h8,   32'hC,  32'h33333193));
        // redirect coincident with response in WAIT: dropped, straight back to REQ
        tbl.push_back(mk(1, 0, 1, 32'h44444213, 1, 32'h40,  0,  0, 32'hC,   0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,   0,  1, 32'h40,  0, 32'h0,   32'h0,  NOP));
        // redirect in WAIT -> DROP, response discarded
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 32'h80,  0,  0, 32'h40,  0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 1, 1, 32'h55555293, 0, 32'h0,   0,  0, 32'h80,  0, 32'h0,   32'h0,  NOP));
        // redirect on the accepting cycle -> DROP
        tbl.push_back(mk(1, 1, 0, 32'h0,        1, 32'h300, 0,  1, 32'h80,  0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 1, 32'h66666313, 0, 32'h0,   0,  0, 32'h300, 0, 32'h0,   32'h0,  NOP));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,   0,  1, 32'h300, 0, 32'h0,   32'h0,  NOP));

        // reset both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", -1, 32'(mem_a.imem_req_valid), 32'h0);
        chk("rst_valid",     -1, 32'(if_id_valid),          32'h0);
        chk("rst_pc",        -1, if_id_pc,                  32'h0);
        chk("rst_pc4",       -1, if_id_pc_plus4,            32'h4);
        chk("rst_instr",     -1, if_id_instruction,         NOP);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n                = tbl[i].rst;
            mem_a.imem_req_ready = tbl[i].rdy;
            mem_a.imem_rsp_valid = tbl[i].rsp_v;
            mem_a.imem_rsp_data  = tbl[i].rsp_d;
            redirect_valid       = tbl[i].redir;
            redirect_pc          = tbl[i].rpc;
            stall                = tbl[i].stl;
            #1;
            chk("req_valid", i, 32'(mem_a.imem_req_valid), 32'(tbl[i].e_rv));
            chk("req_addr",  i, mem_a.imem_req_addr,       tbl[i].e_addr);
            chk("if_valid",  i, 32'(if_id_valid),          32'(tbl[i].e_v));
            chk("if_instr",  i, if_id_instruction,         tbl[i].e_instr);
            if (tbl[i].e_v) begin
                chk("if_pc",  i, if_id_pc,       tbl[i].e_pc);
                chk("if_pc4", i, if_id_pc_plus4, tbl[i].e_pc4);
            end
        end

        // wrap-around instance: reset at 0xFFFF_FFFC, one fetch
        @(negedge clk);
        #1;
        chk("b_rst_pc",  100, pc_b,  32'hFFFF_FFFC);
        chk("b_rst_pc4", 100, pc4_b, 32'h0);
        chk("b_rst_req", 100, 32'(mem_b.imem_req_valid), 32'h0);
        rst_b = 1'b1;
        #1;
        chk("b_req_valid", 101, 32'(mem_b.imem_req_valid), 32'h1);
        chk("b_req_addr",  101, mem_b.imem_req_addr,       32'hFFFF_FFFC);
        mem_b.imem_req_ready = 1'b1;
        @(negedge clk);
        mem_b.imem_req_ready = 1'b0;
        mem_b.imem_rsp_valid = 1'b1;
        mem_b.imem_rsp_data  = 32'h00100093;
        #1;
        chk("b_wait_req", 102, 32'(mem_b.imem_req_valid), 32'h0);
        @(negedge clk);
        mem_b.imem_rsp_valid = 1'b0;
        #1;
        chk("b_valid",     103, 32'(v_b),   32'h1);
        chk("b_pc",        103, pc_b,       32'hFFFF_FFFC);
        chk("b_pc4",       103, pc4_b,      32'h0);
        chk("b_instr",     103, instr_b,    32'h00100093);
        chk("b_next_req",  103, 32'(mem_b.imem_req_valid), 32'h1);
        chk("b_next_addr", 103, mem_b.imem_req_addr,       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
